// File: rtl/debug_halt_controller.sv
// Debug halt controller: gates the core clock enable to run, halt, single-step or resume the core,
// driven by breakpoint requests, debounced panel buttons and a memory-mapped control/status word.
module debug_halt_controller #(
    parameter logic [31:0] DEBUG_ADDRESS   = 32'hFF20_0000,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          RESUME_HOLDOFF  = 2
) (
    input  logic        clock_50mhz,
    input  logic        reset_n,
    input  logic        halt_request,
    input  logic [1:0]  halt_cause,
    input  logic [31:0] pc,
    input  logic        resume_button,
    input  logic        step_button,
    input  logic        wReadEnable,
    input  logic        wWriteEnable,
    input  logic [3:0]  wByteEnable,
    input  logic [31:0] wAddress,
    input  logic [31:0] wWriteData,
    output logic [31:0] wReadData,
    output logic        core_clock_enable,
    output logic        halted
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_HALTED = 2'b01;
    localparam logic [1:0] ST_STEP   = 2'b10;
    localparam logic [1:0] ST_RESUME = 2'b11;

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam int HOLD_W = (RESUME_HOLDOFF > 1) ? $clog2(RESUME_HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RESUME_HOLDOFF > 0) ? RESUME_HOLDOFF - 1 : 0);

    // Bit 0 is the resume button, bit 1 the step button.
    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            acc_q, acc_d;
    logic [1:0]            armed_q;
    logic [1:0]            press_q, press_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]        state_q, state_d;
    logic [31:0]       halted_pc_q, halted_pc_d;
    logic [1:0]        cause_q, cause_d;
    logic [15:0]       halt_count_q, halt_count_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic        ctrl_write;
    logic        step_event;
    logic        resume_event;
    logic        sel_status;
    logic        sel_pc;
    logic [31:0] status_word;
    logic        unused_bits;

    assign btn_raw = {step_button, resume_button};

    // A sample that differs from the accepted level extends the run; matching resets it.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == acc_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                acc_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        press_d = armed_q & acc_q & ~acc_d;
    end

    // Synchronizers reset low, so a button held through reset is never "armed" and cannot press.
    always_ff @(posedge clock_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            acc_q   <= '1;
            armed_q <= '0;
            press_q <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            armed_q <= armed_q | sync2_q;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus slave is single-cycle with no wait states; a control write acts in the cycle it is presented.
    assign ctrl_write   = wWriteEnable & wByteEnable[0] & (wAddress == DEBUG_ADDRESS);
    assign step_event   = press_q[1] | (ctrl_write & wWriteData[1]);
    assign resume_event = press_q[0] | (ctrl_write & wWriteData[0]);
    assign unused_bits  = ^{wByteEnable[3:1], wWriteData[31:2]};

    always_comb begin
        state_d      = state_q;
        halted_pc_d  = halted_pc_q;
        cause_d      = cause_q;
        halt_count_d = halt_count_q;
        hold_d       = hold_q;
        case (state_q)
            ST_RUN: begin
                if (halt_request) begin
                    state_d     = ST_HALTED;
                    halted_pc_d = pc;
                    cause_d     = halt_cause;
                    if (halt_count_q != 16'hFFFF) begin
                        halt_count_d = halt_count_q + 16'd1;
                    end
                end
            end
            ST_HALTED: begin
                if (step_event) begin
                    state_d = ST_STEP;
                end else if (resume_event) begin
                    state_d = ST_RESUME;
                    hold_d  = '0;
                end
            end
            ST_STEP: begin
                state_d     = ST_HALTED;
                halted_pc_d = pc;
            end
            ST_RESUME: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            halted_pc_q  <= '0;
            cause_q      <= '0;
            halt_count_q <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            halted_pc_q  <= halted_pc_d;
            cause_q      <= cause_d;
            halt_count_q <= halt_count_d;
            hold_q       <= hold_d;
        end
    end

    assign core_clock_enable = (state_q != ST_HALTED);
    assign halted            = (state_q == ST_HALTED);

    assign status_word = {halt_count_q, 12'h000, cause_q, state_q};
    assign sel_status  = (wAddress == DEBUG_ADDRESS);
    assign sel_pc      = (wAddress == (DEBUG_ADDRESS + 32'd4));

    assign wReadData = sel_status ? (wReadEnable ? status_word : 32'h0000_0000) :
                       sel_pc     ? (wReadEnable ? halted_pc_q : 32'h0000_0000) :
                                    32'hzzzz_zzzz;

endmodule
